// File: rtl/hs_arb_pkg.sv
// Shared types and constants for the round-robin req/ack channel arbiter.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int N_DEF  = 4;
  localparam int W_DEF  = 8;
  localparam int CW_DEF = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Index width never drops below one bit, even for degenerate sizes.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/hs_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick
  import hs_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  req_rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // Rotating the doubled vector puts the highest-priority sender at bit 0.
  assign req_rot = N'({req, req} >> ptr);
  assign valid   = |req;

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/hs_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack data channel among N senders.
module hs_arbiter
  import hs_arb_pkg::*;
#(
  parameter  int N  = N_DEF,
  parameter  int W  = W_DEF,
  parameter  int CW = CW_DEF,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  s_req,
  input  logic [N*W-1:0] s_data,
  output logic [N-1:0]  s_ack,
  output logic          m_req,
  output logic [W-1:0]  m_data,
  input  logic          m_ack,
  output logic [IW-1:0] grant_id,
  output logic          busy,
  output logic [CW-1:0] xfer_cnt
);

  state_e         state_q;
  logic           m_req_q;
  logic [W-1:0]   m_data_q;
  logic [N-1:0]   s_ack_q;
  logic [IW-1:0]  grant_q;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic           busy_q;

  logic           pick_valid;
  logic [IW-1:0]  pick_idx;
  logic [W-1:0]   pick_data;
  logic           grant_req;
  logic [N-1:0]   grant_onehot;
  logic [W-1:0]   sender_data [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign sender_data[gi] = s_data[gi*W +: W];
    end
  endgenerate

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (s_req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_data    = sender_data[pick_idx];
  assign grant_req    = s_req[grant_q];
  assign grant_onehot = N'(1) << grant_q;
  assign rr_ptr_d     = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
  assign xfer_cnt_d   = xfer_cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      m_req_q    <= 1'b0;
      m_data_q   <= '0;
      s_ack_q    <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      xfer_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // m_ack seen here is a receiver fault and is deliberately ignored.
          if (pick_valid) begin
            grant_q  <= pick_idx;
            m_data_q <= pick_data;
            m_req_q  <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          // The granted s_req is not looked at here, so an early drop still completes.
          if (m_ack) begin
            s_ack_q <= grant_onehot;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (!grant_req) begin
            m_req_q <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!m_ack) begin
            s_ack_q    <= '0;
            rr_ptr_q   <= rr_ptr_d;
            xfer_cnt_q <= xfer_cnt_d;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_ack    = s_ack_q;
  assign m_req    = m_req_q;
  assign m_data   = m_data_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_hs_arbiter.sv
// Directed plus randomized bench for hs_arbiter against a round-robin reference model.
module tb_hs_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   s_req;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_ack;
  logic           m_req;
  logic [W-1:0]   m_data;
  logic           m_ack;
  logic [1:0]     grant_id;
  logic           busy;
  logic [CW-1:0]  xfer_cnt;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  int mcnt   = 0;

  hs_arbiter #(.N(N), .W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_req    (s_req),
    .s_data   (s_data),
    .s_ack    (s_ack),
    .m_req    (m_req),
    .m_data   (m_data),
    .m_ack    (m_ack),
    .grant_id (grant_id),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first requesting sender at or after ptr, wrapping modulo N.
  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_data(input int i, input logic [W-1:0] v);
    s_data[i*W +: W] = v;
  endtask

  function automatic logic [W-1:0] get_data(input int i);
    return s_data[i*W +: W];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_req"}, m_req, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_s_ack"}, s_ack, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_xfer_cnt"}, xfer_cnt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst  = 1'b1;
    mptr = 0;
    mcnt = 0;
  endtask

  // Acts as the receiver for one full transfer; must be entered with the arbiter idle.
  task automatic do_xfer(input int dly1, input int dly2, input bit mangle, input bit early_drop,
                         input string tag, output int g);
    logic [W-1:0] d;
    int n;
    g = model_pick(s_req, mptr);
    if (g < 0) begin
      s_req[0] = 1'b1;
      g = model_pick(s_req, mptr);
    end
    d = get_data(g);

    step();
    n = 1;
    while (m_req !== 1'b1 && n < 8) begin step(); n++; end
    check("grant_latency", n, 1);
    check("grant_id", grant_id, g);
    check("m_data_grant", m_data, d);
    check("busy_req", busy, 1);
    check("s_ack_req", s_ack, 0);

    for (int k = 0; k < dly1; k++) begin
      if (mangle) set_data(g, d + 8'h11);
      if (early_drop) s_req[g] = 1'b0;
      step();
      check("m_data_hold_req", m_data, d);
      check("s_ack_quiet_req", s_ack, 0);
      check("m_req_hold", m_req, 1);
    end

    m_ack = 1'b1;
    step();
    n = 1;
    while (s_ack === '0 && n < 8) begin step(); n++; end
    check("s_ack_onehot", s_ack, 32'(1) << g);
    check("m_data_ack", m_data, d);

    s_req[g] = 1'b0;
    step();
    n = 1;
    while (m_req !== 1'b0 && n < 8) begin step(); n++; end
    check("m_req_fall", m_req, 0);
    check("s_ack_drain", s_ack, 32'(1) << g);

    for (int k = 0; k < dly2; k++) begin
      step();
      check("busy_drain", busy, 1);
      check("s_ack_hold_drain", s_ack, 32'(1) << g);
    end

    m_ack = 1'b0;
    step();
    n = 1;
    while (busy !== 1'b0 && n < 8) begin step(); n++; end
    mptr = (g + 1) % N;
    mcnt = (mcnt + 1) % (1 << CW);
    check("busy_done", busy, 0);
    check("s_ack_done", s_ack, 0);
    check("xfer_cnt", xfer_cnt, mcnt);
    check("grant_id_held", grant_id, g);
    $display("XFER %s sender=%0d data=%02h count=%0d", tag, g, d, mcnt);
  endtask

  initial begin
    int g;
    logic [N-1:0] newreq;

    rst    = 1'b0;
    s_req  = '0;
    s_data = '0;
    m_ack  = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // Receiver fault: m_ack while idle must not start anything.
    m_ack = 1'b1;
    step();
    step();
    check("idle_mack_busy", busy, 0);
    check("idle_mack_m_req", m_req, 0);
    check("idle_mack_s_ack", s_ack, 0);
    m_ack = 1'b0;
    step();

    // Single sender.
    set_data(2, 8'hA5);
    s_req = 4'b0100;
    do_xfer(1, 1, 1'b0, 1'b0, "single", g);
    check("single_cnt", xfer_cnt, 1);

    // All senders continuously requesting: rotation 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < N; i++) set_data(i, 8'(i));
    s_req = '1;
    for (int t = 0; t < 5; t++) begin
      do_xfer(0, 0, 1'b0, 1'b0, "rotate", g);
      check("rr_order", grant_id, t % N);
      s_req[g] = 1'b1;
    end

    // Sender 1 completes, then 1 and 3 together: 3 goes first.
    s_req = '0;
    set_data(1, 8'h31);
    set_data(3, 8'h33);
    s_req = 4'b0010;
    do_xfer(0, 0, 1'b0, 1'b0, "s1_first", g);
    s_req = 4'b1010;
    do_xfer(1, 1, 1'b0, 1'b0, "pair_a", g);
    check("pair_first_is_3", grant_id, 3);
    do_xfer(0, 0, 1'b0, 1'b0, "pair_b", g);
    check("pair_second_is_1", grant_id, 1);

    // Data changed while in REQ must not reach m_data.
    set_data(0, 8'h11);
    s_req = 4'b0001;
    do_xfer(2, 0, 1'b1, 1'b0, "data_change", g);
    check("data_change_sender", grant_id, 0);

    // Granted sender drops s_req early: transfer still completes.
    set_data(2, 8'h7E);
    s_req = 4'b0100;
    do_xfer(2, 1, 1'b0, 1'b1, "early_drop", g);

    // Reset while in ACK for sender 2, with sender 3 pending.
    set_data(2, 8'h42);
    set_data(3, 8'h5C);
    s_req = 4'b0100;
    step();
    check("mid_m_req", m_req, 1);
    m_ack = 1'b1;
    step();
    check("mid_s_ack", s_ack, 4'b0100);
    s_req[3] = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    s_req = 4'b1000;
    m_ack = 1'b0;
    step();
    check("held_in_reset", m_req, 0);
    rst  = 1'b1;
    mptr = 0;
    mcnt = 0;
    do_xfer(0, 0, 1'b0, 1'b0, "after_reset", g);
    check("after_reset_sender", grant_id, 3);

    // Random traffic; with CW=4 the counter wraps several times.
    for (int t = 0; t < 40; t++) begin
      newreq = 4'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (newreq[i] && !s_req[i]) set_data(i, 8'($urandom));
      end
      s_req = s_req | newreq;
      if (s_req == '0) begin
        set_data(t % N, 8'($urandom));
        s_req[t % N] = 1'b1;
      end
      do_xfer($urandom_range(0, 2), $urandom_range(0, 2),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), "random", g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
